// File: rtl/rng_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rng_pkg: FSM state type and LFSR/seed helpers shared by the random source.
// Revision 1.0
// ----------------------------------------------------------------------------
package rng_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Helpers work on a 32-bit container, so channel width is limited to 32 bits.
  localparam int MAX_W = 32;

  function automatic logic [MAX_W-1:0] lfsr_step(input logic [MAX_W-1:0] s,
                                                 input logic [MAX_W-1:0] poly);
    return (s >> 1) ^ (s[0] ? poly : '0);
  endfunction

  // The zero guard is applied to the base before rotation.
  function automatic logic [MAX_W-1:0] seed_for_channel(input logic [MAX_W-1:0] base,
                                                        input int idx,
                                                        input int width);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] b;
    int sh;
    mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
    b    = base & mask;
    if (b == '0) b = MAX_W'(1);
    sh = idx % width;
    return ((b << sh) | (b >> (width - sh))) & mask;
  endfunction

  function automatic logic [MAX_W-1:0] default_poly(input int width);
    case (width)
      3:       return 32'h0000_0006;
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      32:      return 32'h8020_0003;
      default: return 32'h0000_00B8;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/random_channel_gen_lfsr_galois.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lfsr_galois: right-shifting Galois LFSR with reset value and parallel load.
// Revision 1.0
// ----------------------------------------------------------------------------
module lfsr_galois
  import rng_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] POLY      = WIDTH'(default_poly(WIDTH)),
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state
);

  logic [WIDTH-1:0] r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RESET_VAL;
    end else if (load) begin
      r_state <= load_val;
    end else begin
      r_state <= WIDTH'(lfsr_step(MAX_W'(r_state), MAX_W'(POLY)));
    end
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/random_channel_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// random_channel_gen: per-channel LFSR draws limited to 1..MAX_VALUE, plus sum.
// Revision 1.0
// ----------------------------------------------------------------------------
module random_channel_gen
  import rng_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               CHANNELS  = 3,
  parameter logic [WIDTH-1:0] POLY      = WIDTH'(default_poly(WIDTH)),
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(1),
  parameter logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}},
  localparam int              SUM_W     = WIDTH + $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      seed_load,
  input  logic [WIDTH-1:0]          seed_in,
  input  logic                      rd_req,
  output logic                      rand_valid,
  output logic [CHANNELS*WIDTH-1:0] rand_data,
  output logic [SUM_W-1:0]          rand_sum
);

  logic [WIDTH-1:0]          w_lfsr [CHANNELS];
  logic [CHANNELS-1:0]       w_in_range;
  logic [CHANNELS-1:0]       w_take;
  logic [CHANNELS-1:0]       w_accepted_next;
  logic [CHANNELS*WIDTH-1:0] w_data_next;
  logic [SUM_W-1:0]          w_sum_next;
  logic                      w_all_accepted;
  logic                      w_transfer;
  state_t                    w_state_next;

  logic [CHANNELS-1:0]       r_accepted;
  logic [CHANNELS*WIDTH-1:0] r_data;
  logic [SUM_W-1:0]          r_sum;
  logic                      r_valid;
  state_t                    r_state;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [WIDTH-1:0] w_seed;
      assign w_seed = WIDTH'(seed_for_channel(MAX_W'(seed_in), gi, WIDTH));

      lfsr_galois #(
        .WIDTH    (WIDTH),
        .POLY     (POLY),
        .RESET_VAL(WIDTH'(seed_for_channel(MAX_W'(SEED), gi, WIDTH)))
      ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .load    (seed_load),
        .load_val(w_seed),
        .state   (w_lfsr[gi])
      );

      // A full-range bound accepts everything, so skip the always-true compare.
      if (MAX_VALUE == {WIDTH{1'b1}}) begin : g_full
        assign w_in_range[gi] = 1'b1;
      end else begin : g_bound
        assign w_in_range[gi] = (w_lfsr[gi] <= MAX_VALUE);
      end

      assign w_take[gi] = (r_state == FILL) && !r_accepted[gi] && w_in_range[gi];
      assign w_data_next[gi*WIDTH +: WIDTH] = w_take[gi] ? w_lfsr[gi]
                                                         : r_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign w_accepted_next = r_accepted | w_take;
  assign w_all_accepted  = &w_accepted_next;
  assign w_transfer      = rd_req && r_valid;

  always_comb begin
    w_sum_next = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_sum_next = w_sum_next + SUM_W'(w_data_next[i*WIDTH +: WIDTH]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (seed_load) begin
      w_state_next = FILL;
    end else begin
      case (r_state)
        FILL:    if (w_all_accepted) w_state_next = HOLD;
        HOLD:    if (w_transfer)     w_state_next = FILL;
        default: w_state_next = FILL;
      endcase
    end
  end

  // Data and sum are left untouched by seed_load; only validity is withdrawn.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_accepted <= '0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_sum      <= '0;
    end else if (seed_load) begin
      r_accepted <= '0;
      r_valid    <= 1'b0;
    end else if (r_state == FILL) begin
      r_accepted <= w_accepted_next;
      r_data     <= w_data_next;
      if (w_all_accepted) begin
        r_valid <= 1'b1;
        r_sum   <= w_sum_next;
      end
    end else if (w_transfer) begin
      r_accepted <= '0;
      r_valid    <= 1'b0;
    end
  end

  assign rand_valid = r_valid;
  assign rand_data  = r_data;
  assign rand_sum   = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_random_channel_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_random_channel_gen: directed vectors for the 3-channel source, a 1-channel
// bounded instance and a standalone LFSR.  Revision 1.0
// ----------------------------------------------------------------------------
module tb_random_channel_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 3 channels, full range
  logic        a_reset, a_seed_load, a_rd_req, a_valid;
  logic [7:0]  a_seed_in;
  logic [23:0] a_data;
  logic [9:0]  a_sum;

  random_channel_gen #(
    .WIDTH(8), .CHANNELS(3), .POLY(8'hB8), .SEED(8'h01), .MAX_VALUE(8'hFF)
  ) u_dut_a (
    .clk(clk), .reset(a_reset), .seed_load(a_seed_load), .seed_in(a_seed_in),
    .rd_req(a_rd_req), .rand_valid(a_valid), .rand_data(a_data), .rand_sum(a_sum)
  );

  // 1 channel, draws limited to 1..0x10
  logic        b_reset, b_seed_load, b_rd_req, b_valid;
  logic [7:0]  b_seed_in;
  logic [7:0]  b_data;
  logic [7:0]  b_sum;

  random_channel_gen #(
    .WIDTH(8), .CHANNELS(1), .POLY(8'hB8), .SEED(8'h01), .MAX_VALUE(8'h10)
  ) u_dut_b (
    .clk(clk), .reset(b_reset), .seed_load(b_seed_load), .seed_in(b_seed_in),
    .rd_req(b_rd_req), .rand_valid(b_valid), .rand_data(b_data), .rand_sum(b_sum)
  );

  logic       l_reset, l_load;
  logic [7:0] l_load_val, l_state;

  lfsr_galois #(.WIDTH(8), .POLY(8'hB8), .RESET_VAL(8'h01)) u_lfsr (
    .clk(clk), .reset(l_reset), .load(l_load), .load_val(l_load_val), .state(l_state)
  );

  typedef struct {
    logic        reset;
    logic        seed_load;
    logic [7:0]  seed_in;
    logic        rd_req;
    logic        exp_valid;
    logic [23:0] exp_data;
    logic [9:0]  exp_sum;
  } vec_t;

  vec_t vecs[32];
  int   nv = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic add_vec(input logic rst, input logic sl, input logic [7:0] sin,
                         input logic rd, input logic ev, input logic [23:0] ed,
                         input logic [9:0] es);
    vecs[nv].reset     = rst;
    vecs[nv].seed_load = sl;
    vecs[nv].seed_in   = sin;
    vecs[nv].rd_req    = rd;
    vecs[nv].exp_valid = ev;
    vecs[nv].exp_data  = ed;
    vecs[nv].exp_sum   = es;
    nv++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [7:0] exp_seq [5];
  int         n;
  int         steps;
  logic       zero_seen;

  initial begin
    a_reset = 1'b1; a_seed_load = 1'b0; a_seed_in = 8'h00; a_rd_req = 1'b0;
    b_reset = 1'b1; b_seed_load = 1'b0; b_seed_in = 8'h00; b_rd_req = 1'b0;
    l_reset = 1'b1; l_load = 1'b0; l_load_val = 8'h00;

    // {reset, seed_load, seed_in, rd_req} -> {valid, data, sum} after the edge
    add_vec(1, 0, 8'h00, 0, 0, 24'h000000, 10'h000);
    add_vec(1, 0, 8'h00, 0, 0, 24'h000000, 10'h000);
    add_vec(0, 0, 8'h00, 0, 1, 24'h040201, 10'h007);
    for (int i = 0; i < 10; i++) add_vec(0, 0, 8'h00, 0, 1, 24'h040201, 10'h007);
    add_vec(0, 0, 8'h00, 1, 0, 24'h040201, 10'h007);   // transfer
    add_vec(0, 0, 8'h00, 0, 1, 24'h19B45A, 10'h127);   // lanes at steps 10/11/12
    add_vec(0, 1, 8'h00, 0, 0, 24'h19B45A, 10'h127);   // seed_load in HOLD
    add_vec(0, 0, 8'h00, 0, 1, 24'h040201, 10'h007);
    add_vec(0, 1, 8'h00, 1, 0, 24'h040201, 10'h007);   // seed_load + rd_req
    add_vec(0, 0, 8'h00, 0, 1, 24'h040201, 10'h007);
    add_vec(0, 0, 8'h00, 1, 0, 24'h040201, 10'h007);   // transfer into FILL
    add_vec(0, 1, 8'h00, 0, 0, 24'h040201, 10'h007);   // seed_load in FILL
    add_vec(0, 0, 8'h00, 0, 1, 24'h040201, 10'h007);
    add_vec(0, 1, 8'h81, 0, 0, 24'h040201, 10'h007);   // nonzero runtime seed
    add_vec(0, 0, 8'h00, 0, 1, 24'h060381, 10'h08A);
    add_vec(1, 0, 8'h00, 1, 0, 24'h000000, 10'h000);   // reset in HOLD with rd_req
    add_vec(0, 0, 8'h00, 0, 1, 24'h040201, 10'h007);

    for (int i = 0; i < nv; i++) begin
      a_reset     = vecs[i].reset;
      a_seed_load = vecs[i].seed_load;
      a_seed_in   = vecs[i].seed_in;
      a_rd_req    = vecs[i].rd_req;
      @(posedge clk); #1;
      check($sformatf("vec%0d {valid,data,sum}", i),
            64'({a_valid, a_data, a_sum}),
            64'({vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_sum}));
    end
    a_reset = 1'b0; a_seed_load = 1'b0; a_rd_req = 1'b0;

    // Bounded channel: 01 accepted, then the LFSR walks past values > 0x10 until 0C
    @(posedge clk); #1;
    b_reset = 1'b0;
    check("b_reset_state", 64'({b_valid, b_data, b_sum}), 64'({1'b0, 8'h00, 8'h00}));
    @(posedge clk); #1;
    check("b_first_draw", 64'({b_valid, b_data, b_sum}), 64'({1'b1, 8'h01, 8'h01}));
    b_rd_req = 1'b1;
    @(posedge clk); #1;
    b_rd_req = 1'b0;
    check("b_valid_after_transfer", 64'(b_valid), 64'(1'b0));
    n = 0;
    while (!b_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("b_stall_cycles", 64'(n), 64'(21));
    check("b_accepted_draw", 64'({b_valid, b_data, b_sum}), 64'({1'b1, 8'h0C, 8'h0C}));

    // Standalone LFSR sequence, load and period
    exp_seq = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
    @(posedge clk); #1;
    check("lfsr_reset", 64'(l_state), 64'(8'h01));
    l_reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("lfsr_step%0d", k + 1), 64'(l_state), 64'(exp_seq[k]));
    end
    steps = 5;
    zero_seen = 1'b0;
    while (l_state != 8'h01 && steps < 300) begin
      @(posedge clk); #1;
      steps++;
      if (l_state == 8'h00) zero_seen = 1'b1;
    end
    check("lfsr_period", 64'(steps), 64'(255));
    check("lfsr_no_zero", 64'(zero_seen), 64'(1'b0));
    l_load = 1'b1;
    l_load_val = 8'h5A;
    @(posedge clk); #1;
    l_load = 1'b0;
    check("lfsr_load", 64'(l_state), 64'(8'h5A));
    @(posedge clk); #1;
    check("lfsr_step_after_load", 64'(l_state), 64'(8'h2D));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
